// File: rtl/pipeline_stall_ctrl.sv
// Central stall/flush/redirect control for the five-stage pipeline.
// Owns the divider busy sequencer and the deferred exception-redirect sequencer.
module pipeline_stall_ctrl #(
    parameter int DIV_CYCLES = 32
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_stcl_lw,
    input  logic        i_stcl_jmp,
    input  logic        i_if_stall_req,
    input  logic        i_mem_stall_req,
    input  logic        i_div_start,
    input  logic        i_exc_valid,
    input  logic [31:0] i_exc_pc,
    output logic        o_pc_stall,
    output logic        o_if_id_stall,
    output logic        o_id_exe_stall,
    output logic        o_exe_mem_stall,
    output logic        o_if_id_flush,
    output logic        o_id_exe_flush,
    output logic        o_exe_mem_flush,
    output logic        o_mem_wb_flush,
    output logic        o_redirect_valid,
    output logic [31:0] o_redirect_pc,
    output logic        o_div_done,
    output logic        o_div_abort,
    output logic [31:0] o_stall_cycles
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DIV_BUSY = 2'd1,
        EXC_WAIT = 2'd2
    } state_t;

    localparam logic [7:0] DIV_LOAD = 8'(DIV_CYCLES - 1);

    state_t      r_state;
    state_t      w_next_state;
    logic [7:0]  r_div_cnt;
    logic [7:0]  w_div_cnt_next;
    logic [31:0] r_exc_pc_q;
    logic [31:0] w_exc_pc_q_next;
    logic [31:0] r_stall_cycles;

    logic        w_div_stall;
    logic        w_pc_stall;
    logic        w_if_id_stall;
    logic        w_id_exe_stall;
    logic        w_exe_mem_stall;
    logic        w_if_id_flush;
    logic        w_id_exe_flush;
    logic        w_exe_mem_flush;
    logic        w_mem_wb_flush;
    logic        w_redirect_valid;
    logic [31:0] w_redirect_pc;
    logic        w_div_done;
    logic        w_div_abort;

    assign w_div_stall = ((r_state == IDLE) && i_div_start) ||
                         ((r_state == DIV_BUSY) && (r_div_cnt != 8'd0));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state        <= IDLE;
            r_div_cnt      <= 8'd0;
            r_exc_pc_q     <= 32'd0;
            r_stall_cycles <= 32'd0;
        end else begin
            r_state        <= w_next_state;
            r_div_cnt      <= w_div_cnt_next;
            r_exc_pc_q     <= w_exc_pc_q_next;
            r_stall_cycles <= r_stall_cycles + {31'd0, w_pc_stall};
        end
    end

    // A committed exception overrides everything, including the divider sequencer.
    always_comb begin
        w_next_state     = r_state;
        w_div_cnt_next   = r_div_cnt;
        w_exc_pc_q_next  = r_exc_pc_q;
        w_pc_stall       = 1'b0;
        w_if_id_stall    = 1'b0;
        w_id_exe_stall   = 1'b0;
        w_exe_mem_stall  = 1'b0;
        w_if_id_flush    = 1'b0;
        w_id_exe_flush   = 1'b0;
        w_exe_mem_flush  = 1'b0;
        w_mem_wb_flush   = 1'b0;
        w_redirect_valid = 1'b0;
        w_redirect_pc    = 32'd0;
        w_div_done       = 1'b0;
        w_div_abort      = 1'b0;

        if (i_exc_valid) begin
            w_if_id_flush   = 1'b1;
            w_id_exe_flush  = 1'b1;
            w_exe_mem_flush = 1'b1;
            w_mem_wb_flush  = 1'b1;
            if (!i_if_stall_req) begin
                w_redirect_valid = 1'b1;
                w_redirect_pc    = i_exc_pc;
                w_next_state     = IDLE;
            end else begin
                w_exc_pc_q_next  = i_exc_pc;
                w_next_state     = EXC_WAIT;
            end
            if (r_state == DIV_BUSY) begin
                w_div_abort    = 1'b1;
                w_div_cnt_next = 8'd0;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_div_start) begin
                        w_div_cnt_next = DIV_LOAD;
                        w_next_state   = DIV_BUSY;
                    end
                end
                DIV_BUSY: begin
                    if (r_div_cnt != 8'd0) begin
                        w_div_cnt_next = r_div_cnt - 8'd1;
                    end else begin
                        w_div_done   = 1'b1;
                        w_next_state = IDLE;
                    end
                end
                EXC_WAIT: begin
                    if (!i_if_stall_req) begin
                        w_next_state = IDLE;
                    end
                end
                default: begin
                    w_next_state = IDLE;
                end
            endcase

            if (r_state == EXC_WAIT) begin
                w_if_id_flush = 1'b1;
                if (i_if_stall_req) begin
                    w_pc_stall = 1'b1;
                end else begin
                    w_redirect_valid = 1'b1;
                    w_redirect_pc    = r_exc_pc_q;
                end
            end else if (i_mem_stall_req) begin
                w_pc_stall      = 1'b1;
                w_if_id_stall   = 1'b1;
                w_id_exe_stall  = 1'b1;
                w_exe_mem_stall = 1'b1;
                w_mem_wb_flush  = 1'b1;
            end else if (w_div_stall) begin
                w_pc_stall      = 1'b1;
                w_if_id_stall   = 1'b1;
                w_id_exe_stall  = 1'b1;
                w_exe_mem_flush = 1'b1;
            end else if (i_stcl_lw || i_stcl_jmp) begin
                w_pc_stall     = 1'b1;
                w_if_id_stall  = 1'b1;
                w_id_exe_flush = 1'b1;
            end else if (i_if_stall_req) begin
                w_pc_stall    = 1'b1;
                w_if_id_flush = 1'b1;
            end
        end

        if (i_rst) begin
            w_pc_stall = 1'b0;
        end
    end

    // Outputs are held quiet while reset is asserted, whatever the inputs do.
    assign o_pc_stall       = w_pc_stall;
    assign o_if_id_stall    = w_if_id_stall    & ~i_rst;
    assign o_id_exe_stall   = w_id_exe_stall   & ~i_rst;
    assign o_exe_mem_stall  = w_exe_mem_stall  & ~i_rst;
    assign o_if_id_flush    = w_if_id_flush    & ~i_rst;
    assign o_id_exe_flush   = w_id_exe_flush   & ~i_rst;
    assign o_exe_mem_flush  = w_exe_mem_flush  & ~i_rst;
    assign o_mem_wb_flush   = w_mem_wb_flush   & ~i_rst;
    assign o_redirect_valid = w_redirect_valid & ~i_rst;
    assign o_redirect_pc    = i_rst ? 32'd0 : w_redirect_pc;
    assign o_div_done       = w_div_done       & ~i_rst;
    assign o_div_abort      = w_div_abort      & ~i_rst;
    assign o_stall_cycles   = r_stall_cycles;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Self-checking bench for pipeline_stall_ctrl: vector table plus multi-cycle
// sequences, with expected outputs queued on drive and popped on check.
module tb_pipeline_stall_ctrl;

    localparam int DIVC = 4;

    localparam logic [6:0] NONE = 7'b0000000;
    localparam logic [6:0] RST  = 7'b1000000;
    localparam logic [6:0] LW   = 7'b0100000;
    localparam logic [6:0] JMP  = 7'b0010000;
    localparam logic [6:0] IFS  = 7'b0001000;
    localparam logic [6:0] MEMS = 7'b0000100;
    localparam logic [6:0] DIVS = 7'b0000010;
    localparam logic [6:0] EXC  = 7'b0000001;

    typedef struct {
        logic [6:0]  in;
        logic [31:0] pc;
        logic [3:0]  st;
        logic [3:0]  fl;
        logic        rv;
        logic [31:0] rpc;
        logic        done;
        logic        abort;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        stcl_lw;
    logic        stcl_jmp;
    logic        if_stall_req;
    logic        mem_stall_req;
    logic        div_start;
    logic        exc_valid;
    logic [31:0] exc_pc;
    logic        pc_stall;
    logic        if_id_stall;
    logic        id_exe_stall;
    logic        exe_mem_stall;
    logic        if_id_flush;
    logic        id_exe_flush;
    logic        exe_mem_flush;
    logic        mem_wb_flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        div_done;
    logic        div_abort;
    logic [31:0] stall_cycles;

    vec_t        expQ[$];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] modelStallCycles = 32'd0;

    pipeline_stall_ctrl #(.DIV_CYCLES(DIVC)) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_stcl_lw       (stcl_lw),
        .i_stcl_jmp      (stcl_jmp),
        .i_if_stall_req  (if_stall_req),
        .i_mem_stall_req (mem_stall_req),
        .i_div_start     (div_start),
        .i_exc_valid     (exc_valid),
        .i_exc_pc        (exc_pc),
        .o_pc_stall      (pc_stall),
        .o_if_id_stall   (if_id_stall),
        .o_id_exe_stall  (id_exe_stall),
        .o_exe_mem_stall (exe_mem_stall),
        .o_if_id_flush   (if_id_flush),
        .o_id_exe_flush  (id_exe_flush),
        .o_exe_mem_flush (exe_mem_flush),
        .o_mem_wb_flush  (mem_wb_flush),
        .o_redirect_valid(redirect_valid),
        .o_redirect_pc   (redirect_pc),
        .o_div_done      (div_done),
        .o_div_abort     (div_abort),
        .o_stall_cycles  (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [6:0] in, input logic [31:0] pc,
                                input logic [3:0] st, input logic [3:0] fl,
                                input logic rv, input logic [31:0] rpc,
                                input logic done, input logic abort);
        vec_t v;
        v.in = in; v.pc = pc; v.st = st; v.fl = fl;
        v.rv = rv; v.rpc = rpc; v.done = done; v.abort = abort;
        return v;
    endfunction

    // Drive one cycle's inputs and queue what the outputs must be.
    task automatic applyStimulus(input vec_t v);
        rst           = v.in[6];
        stcl_lw       = v.in[5];
        stcl_jmp      = v.in[4];
        if_stall_req  = v.in[3];
        mem_stall_req = v.in[2];
        div_start     = v.in[1];
        exc_valid     = v.in[0];
        exc_pc        = v.pc;
        expQ.push_back(v);
    endtask

    // Pop the expected record and compare the combinational outputs and counter.
    task automatic checkOutput(input string name);
        vec_t        e;
        logic [43:0] act;
        logic [43:0] req;
        checks++;
        if (expQ.size() == 0) begin
            errors++;
            $display("[TB] FAIL %s: scoreboard empty", name);
            return;
        end
        e   = expQ.pop_front();
        act = {pc_stall, if_id_stall, id_exe_stall, exe_mem_stall,
               if_id_flush, id_exe_flush, exe_mem_flush, mem_wb_flush,
               redirect_valid, redirect_pc, div_done, div_abort};
        req = {e.st, e.fl, e.rv, e.rpc, e.done, e.abort};
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: outputs st/fl/rv/rpc/done/abort actual=%b/%b/%b/%h/%b/%b required=%b/%b/%b/%h/%b/%b",
                     name, act[43:40], act[39:36], act[35], act[34:3], act[2], act[1],
                     e.st, e.fl, e.rv, e.rpc, e.done, e.abort);
        end
        checks++;
        if (stall_cycles !== modelStallCycles) begin
            errors++;
            $display("[TB] FAIL %s: stall_cycles actual=%0d required=%0d",
                     name, stall_cycles, modelStallCycles);
        end
        if (e.in[6]) modelStallCycles = 32'd0;
        else if (e.st[3]) modelStallCycles = modelStallCycles + 32'd1;
    endtask

    task automatic runCycle(input vec_t v, input string name);
        applyStimulus(v);
        #3;
        checkOutput(name);
        @(posedge clk);
        #1;
    endtask

    vec_t table_v[11];

    initial begin
        table_v[0]  = mk(RST,              32'h0,        4'b0000, 4'b0000, 1'b0, 32'h0,        1'b0, 1'b0);
        table_v[1]  = mk(NONE,             32'h0,        4'b0000, 4'b0000, 1'b0, 32'h0,        1'b0, 1'b0);
        table_v[2]  = mk(LW,               32'h0,        4'b1100, 4'b0100, 1'b0, 32'h0,        1'b0, 1'b0);
        table_v[3]  = mk(JMP,              32'h0,        4'b1100, 4'b0100, 1'b0, 32'h0,        1'b0, 1'b0);
        table_v[4]  = mk(IFS,              32'h0,        4'b1000, 4'b1000, 1'b0, 32'h0,        1'b0, 1'b0);
        table_v[5]  = mk(MEMS,             32'h0,        4'b1111, 4'b0001, 1'b0, 32'h0,        1'b0, 1'b0);
        table_v[6]  = mk(MEMS | LW | IFS,  32'h0,        4'b1111, 4'b0001, 1'b0, 32'h0,        1'b0, 1'b0);
        table_v[7]  = mk(LW | IFS,         32'h0,        4'b1100, 4'b0100, 1'b0, 32'h0,        1'b0, 1'b0);
        table_v[8]  = mk(EXC,              32'hBFC00380, 4'b0000, 4'b1111, 1'b1, 32'hBFC00380, 1'b0, 1'b0);
        table_v[9]  = mk(EXC | MEMS | LW | DIVS, 32'h12345678, 4'b0000, 4'b1111, 1'b1, 32'h12345678, 1'b0, 1'b0);
        table_v[10] = mk(RST | LW | MEMS,  32'h0,        4'b0000, 4'b0000, 1'b0, 32'h0,        1'b0, 1'b0);

        rst = 1'b1; stcl_lw = 1'b0; stcl_jmp = 1'b0; if_stall_req = 1'b0;
        mem_stall_req = 1'b0; div_start = 1'b0; exc_valid = 1'b0; exc_pc = 32'h0;
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < 11; i++) begin
            runCycle(table_v[i], $sformatf("table%0d", i));
        end

        // Plain divide: EXE held DIVC cycles, then a single done pulse.
        runCycle(mk(DIVS, 0, 4'b1110, 4'b0010, 0, 0, 0, 0), "div_start");
        for (int i = 1; i < DIVC; i++)
            runCycle(mk(NONE, 0, 4'b1110, 4'b0010, 0, 0, 0, 0), $sformatf("div_busy%0d", i));
        runCycle(mk(NONE, 0, 4'b0000, 4'b0000, 0, 0, 1, 0), "div_done");
        runCycle(mk(NONE, 0, 4'b0000, 4'b0000, 0, 0, 0, 0), "div_after");

        // Memory stall overlaps the divide without freezing its counter.
        runCycle(mk(DIVS, 0, 4'b1110, 4'b0010, 0, 0, 0, 0), "divmem_c0");
        runCycle(mk(MEMS, 0, 4'b1111, 4'b0001, 0, 0, 0, 0), "divmem_c1");
        runCycle(mk(MEMS, 0, 4'b1111, 4'b0001, 0, 0, 0, 0), "divmem_c2");
        runCycle(mk(DIVS, 0, 4'b1110, 4'b0010, 0, 0, 0, 0), "divmem_c3");
        runCycle(mk(DIVS, 0, 4'b0000, 4'b0000, 0, 0, 1, 0), "divmem_done");
        runCycle(mk(NONE, 0, 4'b0000, 4'b0000, 0, 0, 0, 0), "divmem_after");

        // Deferred redirect while the I-cache is busy; lower sources ignored.
        runCycle(mk(EXC | IFS, 32'h80000180, 4'b0000, 4'b1111, 0, 0, 0, 0), "dexc_c0");
        runCycle(mk(IFS,             0, 4'b1000, 4'b1000, 0, 0, 0, 0), "dexc_w1");
        runCycle(mk(IFS | LW | DIVS, 0, 4'b1000, 4'b1000, 0, 0, 0, 0), "dexc_w2");
        runCycle(mk(IFS,             0, 4'b1000, 4'b1000, 0, 0, 0, 0), "dexc_w3");
        runCycle(mk(NONE, 0, 4'b0000, 4'b1000, 1, 32'h80000180, 0, 0), "dexc_redir");
        runCycle(mk(NONE, 0, 4'b0000, 4'b0000, 0, 0, 0, 0), "dexc_after");

        // A second exception in EXC_WAIT replaces the stored target.
        runCycle(mk(EXC | IFS, 32'hA0000000, 4'b0000, 4'b1111, 0, 0, 0, 0), "ovr_c0");
        runCycle(mk(EXC | IFS, 32'hA0000004, 4'b0000, 4'b1111, 0, 0, 0, 0), "ovr_c1");
        runCycle(mk(NONE, 0, 4'b0000, 4'b1000, 1, 32'hA0000004, 0, 0), "ovr_redir");

        // Exception aborts a running divide; a new divide is then accepted.
        runCycle(mk(DIVS, 0, 4'b1110, 4'b0010, 0, 0, 0, 0), "abort_c0");
        runCycle(mk(NONE, 0, 4'b1110, 4'b0010, 0, 0, 0, 0), "abort_c1");
        runCycle(mk(EXC, 32'hBFC00200, 4'b0000, 4'b1111, 1, 32'hBFC00200, 0, 1), "abort_exc");
        runCycle(mk(DIVS, 0, 4'b1110, 4'b0010, 0, 0, 0, 0), "abort_restart");
        for (int i = 1; i < DIVC; i++)
            runCycle(mk(NONE, 0, 4'b1110, 4'b0010, 0, 0, 0, 0), $sformatf("abort_busy%0d", i));
        runCycle(mk(NONE, 0, 4'b0000, 4'b0000, 0, 0, 1, 0), "abort_done");

        // Abort combined with a deferred redirect.
        runCycle(mk(DIVS, 0, 4'b1110, 4'b0010, 0, 0, 0, 0), "abwait_c0");
        runCycle(mk(EXC | IFS, 32'h00000040, 4'b0000, 4'b1111, 0, 0, 0, 1), "abwait_exc");
        runCycle(mk(NONE, 0, 4'b0000, 4'b1000, 1, 32'h00000040, 0, 0), "abwait_redir");

        // Reset discards a pending redirect and a running divide.
        runCycle(mk(EXC | IFS, 32'hDEAD0000, 4'b0000, 4'b1111, 0, 0, 0, 0), "rst_exc");
        runCycle(mk(RST | IFS, 0, 4'b0000, 4'b0000, 0, 0, 0, 0), "rst_wait");
        runCycle(mk(NONE, 0, 4'b0000, 4'b0000, 0, 0, 0, 0), "rst_noredir");
        runCycle(mk(DIVS, 0, 4'b1110, 4'b0010, 0, 0, 0, 0), "rst_div0");
        runCycle(mk(NONE, 0, 4'b1110, 4'b0010, 0, 0, 0, 0), "rst_div1");
        runCycle(mk(RST, 0, 4'b0000, 4'b0000, 0, 0, 0, 0), "rst_div");
        for (int i = 0; i < DIVC; i++)
            runCycle(mk(NONE, 0, 4'b0000, 4'b0000, 0, 0, 0, 0), $sformatf("rst_nodone%0d", i));

        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain: leftover=%0d required=0", expQ.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipeline_stall_ctrl.md
# pipeline_stall_ctrl

Central pipeline control for the five-stage MIPS core. It consumes stall requests from the ID-stage hazard unit (load-use and branch-operand stalls), the I-cache and D-cache, and the multi-cycle divider. It also consumes exception/redirect requests from MEM. From these it drives prioritised per-register stall/flush controls for PC, IF/ID, ID/EXE, EXE/MEM and MEM/WB. The block owns the divider busy sequencer and the deferred exception-redirect sequencer.

## Interface
- DIV_CYCLES, 32: cycles the EXE stage is held per divide; legal range 2..255.
- clk  in  1  pipeline clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- stcl_lw  in  1  load-use / SC-use stall request from ID hazard detection.
- stcl_jmp  in  1  branch/jump operand-not-ready stall request from ID hazard detection.
- if_stall_req  in  1  I-cache miss in progress; the fetch result is not valid.
- mem_stall_req  in  1  D-cache/uncached access in progress in MEM.
- div_start  in  1  a div/divu is in EXE and must begin; sampled only in IDLE.
- exc_valid  in  1  exception or eret is committed in MEM this cycle.
- exc_pc  in  32  redirect target accompanying exc_valid.
- pc_stall, if_id_stall, id_exe_stall, exe_mem_stall  out  1 each  hold the register.
- if_id_flush, id_exe_flush, exe_mem_flush, mem_wb_flush  out  1 each  load a bubble (nop) into the register.
- redirect_valid  out  1  load PC with redirect_pc this cycle.
- redirect_pc  out  32  redirect target.
- div_done  out  1  one-cycle pulse; divider result is valid in EXE.
- div_abort  out  1  one-cycle pulse; divide cancelled by an exception.
- stall_cycles  out  32  count of cycles with pc_stall=1.

## Operation
- State machine: IDLE, DIV_BUSY, EXC_WAIT. There is an 8-bit down-counter div_cnt and a 32-bit exc_pc_q.
- Reset: state=IDLE, div_cnt=0, exc_pc_q=0, stall_cycles=0. Every output is 0 during and after reset until the inputs dictate otherwise.
- Stall/flush resolution is combinational. The highest-priority active source wins, and lower sources are ignored that cycle:
  1. exc_valid (any state): all four flush outputs are 1 and all stall outputs are 0.
     - If if_stall_req=0: redirect_valid=1 and redirect_pc=exc_pc this cycle; next state is IDLE.
     - Else: redirect_valid=0, exc_pc_q<=exc_pc, and next state is EXC_WAIT.
     - If state was DIV_BUSY, div_abort=1 and div_cnt<=0.
  2. state=EXC_WAIT: pc_stall=1 and if_id_flush=1.
     - When if_stall_req=0: redirect_valid=1, redirect_pc=exc_pc_q, pc_stall=0, and next state is IDLE.
  3. mem_stall_req: pc_stall, if_id_stall, id_exe_stall and exe_mem_stall are 1; mem_wb_flush=1.
  4. div_stall: pc_stall, if_id_stall and id_exe_stall are 1; exe_mem_flush=1.
  5. stcl_lw | stcl_jmp: pc_stall and if_id_stall are 1; id_exe_flush=1.
  6. if_stall_req: pc_stall=1 and if_id_flush=1.
- div_stall is defined as (state==IDLE & div_start) | (state==DIV_BUSY & div_cnt!=0).
- Divider sequencer: runs independently of mem_stall_req, which never freezes the counter.
  - IDLE & div_start & !exc_valid: div_cnt<=DIV_CYCLES-1 and next state is DIV_BUSY.
  - In DIV_BUSY with div_cnt!=0: div_cnt decrements.
  - In DIV_BUSY with div_cnt==0: div_done=1, next state is IDLE, and div_stall=0 that cycle.
  - div_start outside IDLE is ignored.
- EXC_WAIT ignores div_start.
- A new exc_valid in EXC_WAIT overwrites exc_pc_q (the newest redirect wins).
- stall_cycles increments by 1 on every cycle with pc_stall=1 and wraps modulo 2^32. It is not cleared except by rst.
- If a stall and a flush are computed for the same register, flush wins. This can only occur through rule 1.

## Timing
- All stall, flush and redirect outputs are combinational from the inputs and the current state. There is zero cycle latency into the pipeline registers' enables.
- A divide started at cycle t holds EXE for exactly DIV_CYCLES cycles (t..t+DIV_CYCLES-1).
  - div_done pulses at t+DIV_CYCLES; EXE advances on that cycle's edge unless a higher-priority stall is active.
- A deferred exception produces redirect_valid in the first cycle with if_stall_req=0, at the earliest the cycle after exc_valid.
- rst asserted mid-divide or in EXC_WAIT returns the block to IDLE on the next edge; the pending redirect is discarded.

## Test plan
- stcl_lw=1 for 1 cycle, nothing else -> pc_stall=1, if_id_stall=1, id_exe_flush=1 for that cycle; stall_cycles goes 0->1.
- DIV_CYCLES=4, div_start at cycle 10 -> id_exe_stall=1 cycles 10-13, exe_mem_flush=1 cycles 10-13, div_done=1 at cycle 14 only.
- div_start at cycle 10, mem_stall_req=1 cycles 11-12 -> exe_mem_stall=1 and mem_wb_flush=1 at 11-12; div_done still at cycle 14.
- exc_valid with exc_pc=0xBFC00380 and if_stall_req=0 -> all four flushes=1, redirect_valid=1, redirect_pc=0xBFC00380 in the same cycle.
- exc_valid (exc_pc=0x80000180) with if_stall_req=1 held 3 more cycles -> EXC_WAIT with pc_stall=1 and if_id_flush=1 for 3 cycles, then redirect_valid=1 with 0x80000180 in the cycle if_stall_req falls.
- exc_valid at cycle 12 of a divide started at cycle 10 -> div_abort=1 at cycle 12, no div_done, state returns to IDLE; a div_start at cycle 13 is accepted.
